// File: rtl/sram_arbiter.sv
// Two-port (CPU A / accelerator B) arbiter onto one single-cycle SRAM, with owner lock and read-return routing.
// Optional macro SRAM_ARB_RR_EN selects round-robin contention; otherwise A has fixed priority.
module sram_arbiter #(
  parameter int AW = 14
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          A_REQ,
  input  logic          A_LOCK,
  input  logic [AW-1:0] A_ADDR,
  input  logic [31:0]   A_WDATA,
  input  logic [3:0]    A_WREN,
  output logic          A_GNT,
  output logic          A_RVALID,
  output logic [31:0]   A_RDATA,
  input  logic          B_REQ,
  input  logic          B_LOCK,
  input  logic [AW-1:0] B_ADDR,
  input  logic [31:0]   B_WDATA,
  input  logic [3:0]    B_WREN,
  output logic          B_GNT,
  output logic          B_RVALID,
  output logic [31:0]   B_RDATA,
  output logic          S_CS,
  output logic [AW-1:0] S_ADDR,
  output logic [31:0]   S_WDATA,
  output logic [3:0]    S_WREN,
  input  logic [31:0]   S_RDATA
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t        state_q, state_d;
  logic          rvalid_a_q, rvalid_a_d;
  logic          rvalid_b_q, rvalid_b_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          lock_a, lock_b, a_wins;
  logic          gnt_a, gnt_b;
`ifdef SRAM_ARB_RR_EN
  logic          last_b_q, last_b_d;
`endif

  // A lock only holds while its owner keeps requesting; dropping REQ reopens arbitration at once.
  always_comb begin
    lock_a = (state_q == OWN_A) && A_LOCK && A_REQ;
    lock_b = (state_q == OWN_B) && B_LOCK && B_REQ;
`ifdef SRAM_ARB_RR_EN
    a_wins = last_b_q;
`else
    a_wins = 1'b1;
`endif
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (lock_a) begin
      gnt_a = 1'b1;
    end else if (lock_b) begin
      gnt_b = 1'b1;
    end else if (A_REQ && B_REQ) begin
      gnt_a = a_wins;
      gnt_b = !a_wins;
    end else begin
      gnt_a = A_REQ;
      gnt_b = B_REQ;
    end
    gnt_a = gnt_a & RESETn;
    gnt_b = gnt_b & RESETn;
  end

  always_comb begin
    A_GNT   = gnt_a;
    B_GNT   = gnt_b;
    S_CS    = gnt_a | gnt_b;
    S_ADDR  = addr_q;
    S_WDATA = '0;
    S_WREN  = '0;
    if (gnt_a) begin
      S_ADDR  = A_ADDR;
      S_WDATA = A_WDATA;
      S_WREN  = A_WREN;
    end else if (gnt_b) begin
      S_ADDR  = B_ADDR;
      S_WDATA = B_WDATA;
      S_WREN  = B_WREN;
    end
    addr_d     = S_ADDR;
    rvalid_a_d = gnt_a && (A_WREN == 4'b0000);
    rvalid_b_d = gnt_b && (B_WREN == 4'b0000);
    if (gnt_a)      state_d = OWN_A;
    else if (gnt_b) state_d = OWN_B;
    else            state_d = IDLE;
`ifdef SRAM_ARB_RR_EN
    last_b_d = last_b_q;
    if (gnt_a)      last_b_d = 1'b0;
    else if (gnt_b) last_b_d = 1'b1;
`endif
    A_RVALID = rvalid_a_q;
    B_RVALID = rvalid_b_q;
    A_RDATA  = rvalid_a_q ? S_RDATA : 32'h0;
    B_RDATA  = rvalid_b_q ? S_RDATA : 32'h0;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= IDLE;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      addr_q     <= '0;
`ifdef SRAM_ARB_RR_EN
      last_b_q   <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      addr_q     <= addr_d;
`ifdef SRAM_ARB_RR_EN
      last_b_q   <= last_b_d;
`endif
    end
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 14, the SRAM word-address width.
REQ-002 The block SHALL have input CLK, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input RESETn, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port A, the CPU side: inputs A_REQ (1), A_LOCK (1), A_ADDR (AW), A_WDATA (32), A_WREN (4); outputs A_GNT (1), A_RVALID (1), A_RDATA (32).
REQ-005 The block SHALL have port B, the accelerator side: inputs B_REQ, B_LOCK, B_ADDR, B_WDATA, B_WREN; outputs B_GNT, B_RVALID, B_RDATA. Widths are identical to port A.
REQ-006 The block SHALL have SRAM-side outputs S_CS (1), S_ADDR (AW), S_WDATA (32) and S_WREN (4), and input S_RDATA (32).

Function
REQ-007 A transfer SHALL occur on every cycle where X_REQ and X_GNT are both high; X_WREN==0 means a read, and any nonzero X_WREN means a byte-lane write.
REQ-008 Grant SHALL be combinational from the requests and registered state. At most one of A_GNT/B_GNT SHALL be high in any cycle, and a GNT SHALL never be high without its own REQ.
REQ-009 S_CS SHALL equal A_GNT|B_GNT. S_ADDR, S_WDATA and S_WREN SHALL be muxed from the granted port. When neither port is granted, S_WREN SHALL be 0, S_ADDR the last driven value, and S_WDATA 0.
REQ-010 State machine states SHALL be IDLE, OWN_A and OWN_B; the state holds the owner of the previous transfer.
REQ-011 In OWN_A with A_LOCK=1 and A_REQ=1, port A SHALL be granted regardless of B_REQ. OWN_B with B_LOCK and B_REQ SHALL behave symmetrically for port B.
REQ-012 With no active lock, the block SHALL arbitrate by the priority rule in REQ-021 or REQ-022.
REQ-013 Next state SHALL be OWN_A or OWN_B after a grant to A or B respectively, and IDLE in a cycle with no grant.
REQ-014 After a granted read, X_RVALID SHALL pulse high for exactly the next cycle, and X_RDATA SHALL equal S_RDATA during that cycle. This matches the SRAM's 1-cycle registered-address read latency.
REQ-015 X_RDATA SHALL be 0 whenever X_RVALID is low, and a granted write SHALL produce no RVALID.
REQ-016 Back-to-back reads, including reads alternating between ports, SHALL achieve 1 transfer per cycle, with each RVALID routed to the port that issued the read.
REQ-017 If a requester drops X_REQ while holding a lock, the lock SHALL be released immediately and arbitration SHALL be normal in that same cycle.
REQ-018 Simultaneous A_REQ and B_REQ from IDLE with no lock SHALL be resolved by the priority rule. No cycle with a pending request SHALL be left idle.

Reset
REQ-019 While RESETn is low, state SHALL be IDLE, the last-granted register SHALL be B (so A wins first), and A_RVALID/B_RVALID SHALL be 0. All GNT outputs, S_CS and S_WREN SHALL be 0, since GNT is forced low during reset.
REQ-020 Reset asserted mid-operation SHALL discard any pending RVALID, and the read data of that cycle SHALL never be delivered after reset release.

Configuration
REQ-021 With SRAM_ARB_RR_EN defined, unlocked contention SHALL be resolved round-robin: the port not granted most recently wins, and the last-granted register updates on every grant.
REQ-022 Without SRAM_ARB_RR_EN, port A SHALL always win unlocked contention (fixed priority), and the last-granted register SHALL not exist.

Verification
REQ-023 Reset release, then A_REQ=1 read of ADDR 0x0010 holding 0x12345678 -> A_GNT=1 that cycle, A_RVALID=1 with A_RDATA=0x12345678 the next cycle, B_RVALID=0 throughout.
REQ-024 B write ADDR 0x0020, WREN=4'b0011, WDATA=0xAABBCCDD over 0xFFFFFFFF; then B read 0x0020 -> B_RDATA=0xFFFFCCDD, and no RVALID for the write cycle.
REQ-025 A_REQ and B_REQ held high for 4 cycles with no locks -> RR build grants A,B,A,B; fixed build grants A,A,A,A; each RVALID appears on the issuing port.
REQ-026 B granted with B_LOCK=1 for 3 reads while A_REQ=1 -> A_GNT=0 for those 3 cycles. B_REQ dropping on cycle 4 -> A_GNT=1 on cycle 4.
REQ-027 RESETn pulsed low for 1 cycle in the cycle after a granted A read -> A_RVALID=0 and A_RDATA=0, and the state is IDLE on release.
REQ-028 Random A/B traffic against a reference memory model for 10k cycles -> no double grant, no lost request, and all read data matches the model.
